// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter in front of the single SRAM SPI controller.
// Master 0 is the host SPI bridge and master 1 is the Levenshtein engine.
// Arbitration is round-robin on ties, with one cycle of latency.
// A granted master keeps its grant while its cyc stays high.
// Optional stall watchdog: define WB_SRAM_ARB_TIMEOUT_EN.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   mN_cyc/stb/adr/we/dat_i  master N request (N = 0, 1)
//   mN_ack/err/rty/dat_o     master N termination and read data
//   s_cyc/stb/adr/we/dat_o   request to the SRAM controller
//   s_ack/err/rty/dat_i      SRAM controller termination and data
//   gnt_o                registered one-hot grant {m1,m0}
module wb_sram_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic                  m0_we_i,
    input  logic [7:0]            m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    output logic [7:0]            m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic                  m1_we_i,
    input  logic [7:0]            m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic [7:0]            m1_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic                  s_we_o,
    output logic [7:0]            s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    input  logic [7:0]            s_dat_i,
    output logic [1:0]            gnt_o
);

`ifdef WB_SRAM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    logic [1:0] gnt_q;
    logic       last_gnt_q;
    logic       g0;
    logic       g1;
    logic       cur;
    logic       own_cyc;

    assign g0 = (state_q == GNT0);
    assign g1 = (state_q == GNT1);

`ifdef WB_SRAM_ARB_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       err_q;
    logic       own_stb;
    logic       term;
    logic       stall;

    // In ABORT the aborted owner is already recorded in last_gnt_q.
    assign cur     = g1 | ((state_q == ABORT) & last_gnt_q);
    assign own_stb = cur ? m1_stb_i : m0_stb_i;
    assign term    = s_ack_i | s_err_i | s_rty_i;
    assign stall   = own_stb & ~term;
`else
    assign cur = g1;
`endif

    assign own_cyc = cur ? m1_cyc_i : m0_cyc_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_gnt_q <= 1'b1;
`ifdef WB_SRAM_ARB_TIMEOUT_EN
            wd_q       <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef WB_SRAM_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    // last_gnt_q = 1 means m0 wins a tie.
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                        state_q <= GNT0;
                        gnt_q   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= GNT1;
                        gnt_q   <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (!own_cyc) begin
                        state_q    <= IDLE;
                        gnt_q      <= 2'b00;
                        last_gnt_q <= cur;
`ifdef WB_SRAM_ARB_TIMEOUT_EN
                        wd_q       <= 8'd0;
                    end else if (stall) begin
                        if (wd_q == TO_LIM) begin
                            state_q    <= ABORT;
                            gnt_q      <= 2'b00;
                            last_gnt_q <= cur;
                            err_q      <= 1'b1;
                            wd_q       <= 8'd0;
                        end else begin
                            wd_q <= wd_q + 8'd1;
                        end
                    end else begin
                        wd_q <= 8'd0;
`endif
                    end
                end
`ifdef WB_SRAM_ARB_TIMEOUT_EN
                ABORT: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign s_cyc_o = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign s_stb_o = (g0 & m0_stb_i) | (g1 & m1_stb_i);
    assign s_we_o  = (g0 & m0_we_i) | (g1 & m1_we_i);
    assign s_adr_o = g0 ? m0_adr_i : (g1 ? m1_adr_i : '0);
    assign s_dat_o = g0 ? m0_dat_i : (g1 ? m1_dat_i : 8'h00);

    assign m0_ack_o = g0 & s_ack_i;
    assign m1_ack_o = g1 & s_ack_i;
    assign m0_rty_o = g0 & s_rty_i;
    assign m1_rty_o = g1 & s_rty_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_SRAM_ARB_TIMEOUT_EN
    assign m0_err_o = (g0 & s_err_i) | (err_q & ~last_gnt_q);
    assign m1_err_o = (g1 & s_err_i) | (err_q & last_gnt_q);
`else
    logic unused_cfg;
    assign unused_cfg = ^TO_LIM;
    assign m0_err_o   = g0 & s_err_i;
    assign m1_err_o   = g1 & s_err_i;
`endif

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed scenarios then random traffic.
// Expected values come from an owner/last-served reference model.
module tb_wb_sram_arbiter;
    localparam int AW = 23;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cyc;
    logic [1:0]    stb;
    logic [1:0]    we;
    logic [AW-1:0] adr [2];
    logic [7:0]    wdat [2];
    logic          s_ack;
    logic          s_err;
    logic          s_rty;
    logic [7:0]    s_rdat;

    logic          m0_ack, m0_err, m0_rty;
    logic          m1_ack, m1_err, m1_rty;
    logic [7:0]    m0_rd, m1_rd;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [7:0]    s_wd;
    logic [1:0]    gnt;

    int total = 0;
    int bad   = 0;
    // model: current owner (-1 none), last served, stall count,
    // aborted owner (-1 none), err pulse target (-1 none)
    int own, last, wd, ab, pulse;
    int beats [2];
    int sc;

    always #5 clk = ~clk;

    wb_sram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_adr_i(adr[0]),
        .m0_we_i(we[0]), .m0_dat_i(wdat[0]),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m0_dat_o(m0_rd),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_adr_i(adr[1]),
        .m1_we_i(we[1]), .m1_dat_i(wdat[1]),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .m1_dat_o(m1_rd),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_adr_o(s_adr),
        .s_we_o(s_we), .s_dat_o(s_wd),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .s_dat_i(s_rdat), .gnt_o(gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own   = -1;
        last  = 1;
        wd    = 0;
        ab    = -1;
        pulse = -1;
        sc    = 0;
    endtask

    task automatic check_all(input string tag);
        logic [1:0]    eg;
        logic          ec, es, ew;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        eg = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
        ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; ed = 8'h00;
        if (own >= 0) begin
            ec = cyc[own]; es = stb[own]; ew = we[own];
            ea = adr[own]; ed = wdat[own];
        end
        chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ":scyc"}, 32'(s_cyc), 32'(ec));
        chk({tag, ":sstb"}, 32'(s_stb), 32'(es));
        chk({tag, ":swe"}, 32'(s_we), 32'(ew));
        chk({tag, ":sadr"}, 32'(s_adr), 32'(ea));
        chk({tag, ":sdat"}, 32'(s_wd), 32'(ed));
        chk({tag, ":ack"}, 32'({m1_ack, m0_ack}),
            32'({own == 1 && s_ack, own == 0 && s_ack}));
        chk({tag, ":err"}, 32'({m1_err, m0_err}),
            32'({(own == 1 && s_err) || pulse == 1,
                 (own == 0 && s_err) || pulse == 0}));
        chk({tag, ":rty"}, 32'({m1_rty, m0_rty}),
            32'({own == 1 && s_rty, own == 0 && s_rty}));
        chk({tag, ":rdat"}, 32'({m1_rd, m0_rd}), 32'({s_rdat, s_rdat}));
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        logic t;
        t = s_ack | s_err | s_rty;
        for (int n = 0; n < 2; n++) begin
            if (own == n && cyc[n] && stb[n] && t) begin
                if (beats[n] > 0) beats[n]--;
                adr[n] = adr[n] + 1'b1;
            end
        end
        pulse = -1;
        if (ab >= 0) begin
            if (!cyc[ab]) begin
                last = ab;
                ab   = -1;
            end
        end else if (own < 0) begin
            if (cyc == 2'b11) own = (last == 0) ? 1 : 0;
            else if (cyc[0]) own = 0;
            else if (cyc[1]) own = 1;
        end else if (!cyc[own]) begin
            last = own;
            own  = -1;
            wd   = 0;
        end else begin
`ifdef WB_SRAM_ARB_TIMEOUT_EN
            if (stb[own] && !t) begin
                wd++;
                if (wd >= TO) begin
                    ab    = own;
                    pulse = own;
                    own   = -1;
                    wd    = 0;
                end
            end else begin
                wd = 0;
            end
`endif
        end
        if (ab >= 0) beats[ab] = 0;
    endtask

    task automatic tick(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        adr[0] = '0; adr[1] = '0; wdat[0] = 8'h00; wdat[1] = 8'h00;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = 8'h00;
        beats[0] = 0; beats[1] = 0;
        model_reset();
        @(negedge clk);
        #1 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_rand();
        int k;
        for (int n = 0; n < 2; n++) begin
            if (beats[n] > 0) begin
                cyc[n] = 1'b1;
                stb[n] = ($urandom_range(3) != 0);
            end else if (cyc[n]) begin
                cyc[n] = 1'b0;
                stb[n] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                beats[n] = int'($urandom_range(3, 1));
                adr[n]   = AW'($urandom);
                we[n]    = 1'($urandom);
                wdat[n]  = 8'($urandom);
                cyc[n]   = 1'b1;
                stb[n]   = 1'b1;
            end
        end
        s_rdat = 8'($urandom);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        if (own >= 0 && cyc[own] && stb[own]) begin
            // never stall long enough to trip the watchdog
            if (sc >= 2 || $urandom_range(1) == 1) begin
                k = int'($urandom_range(9));
                if (k == 0) s_err = 1'b1;
                else if (k == 1) s_rty = 1'b1;
                else s_ack = 1'b1;
                sc = 0;
            end else begin
                sc++;
            end
        end else begin
            sc = 0;
            if (own < 0 && $urandom_range(7) == 0) s_ack = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // single m0 write
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = AW'(32'h10); wdat[0] = 8'hA5;
        tick("m0_req");
        chk("m0_gnt", 32'(gnt), 32'h1);
        s_ack = 1'b1;
        #1;
        chk("m0_adr", 32'(s_adr), 32'h10);
        chk("m0_ack", 32'(m0_ack), 32'h1);
        chk("m1_noack", 32'(m1_ack), 32'h0);
        tick("m0_ack");
        s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        tick("m0_rel");

        // simultaneous requests alternate, m0 first
        do_reset();
        cyc = 2'b11; stb = 2'b11;
        tick("both_req");
        for (int k = 0; k < 4; k++) begin
            int w;
            w = k % 2;
            chk("alt_gnt", 32'(gnt), (w == 1) ? 32'h2 : 32'h1);
            s_ack = 1'b1;
            tick("alt_ack");
            s_ack = 1'b0; cyc[w] = 1'b0; stb[w] = 1'b0;
            tick("alt_rel");
            cyc[w] = 1'b1; stb[w] = 1'b1;
            tick("alt_rereq");
        end
        cyc = 2'b00; stb = 2'b00;
        tick("alt_end");
        tick("alt_idle");

        // m1 locked burst while m0 waits
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
        adr[1] = AW'(32'h100);
        tick("m1_req");
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk("m1_adr", 32'(s_adr), 32'h100 + 32'(b));
            s_ack = 1'b1; s_rdat = 8'(b + 3);
            tick("m1_rd");
        end
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        tick("m1_rel");
        chk("gap_gnt", 32'(gnt), 32'h0);
        tick("m0_wait");
        chk("m0_after", 32'(gnt), 32'h1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick("m0_rel2");

        // cyc dropped in the ack cycle
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick("drop_req");
        cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b1;
        #1 chk("drop_ack", 32'(m0_ack), 32'h1);
        tick("drop_ack");
        s_ack = 1'b0;
        chk("drop_rel", 32'(gnt), 32'h0);
        tick("drop_idle");

        // stalled slave
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick("wd_req");
        for (int i = 0; i < TO; i++) tick("wd_stall");
`ifdef WB_SRAM_ARB_TIMEOUT_EN
        #1;
        chk("wd_err", 32'(m0_err), 32'h1);
        chk("wd_scyc", 32'(s_cyc), 32'h0);
        tick("wd_abort");
        chk("wd_pulse", 32'(m0_err), 32'h0);
        chk("wd_hold", 32'(s_cyc), 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick("wd_rel");
        tick("wd_idle");
`else
        for (int i = 0; i < 6; i++) tick("hold_stall");
        chk("hold_gnt", 32'(gnt), 32'h1);
        chk("hold_err", 32'(m0_err), 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick("hold_rel");
        tick("hold_idle");
`endif

        // reset in the middle of an m1 transfer
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick("m1_req2");
        tick("m1_stall");
        #2;
        rst_n = 1'b0;
        s_ack = 1'b1;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_m1ack", 32'(m1_ack), 32'h0);
        chk("rst_m1err", 32'(m1_err), 32'h0);
        check_all("rst_mid");
        @(negedge clk);

        // random traffic
        do_reset();
        repeat (800) begin
            drive_rand();
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
